// File: rtl/brick_field_pkg.sv
// Shared types and helpers for the brick-wall controller.
package brick_field_pkg;

    // Wall controller state: IDLE serves the game, FILL rewrites the wall.
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Address width for a store of n bricks; never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/brick_field_store.sv
// Brick strength memory: one asynchronous scan read port and one write port
// shared between the level fill and ball hits, with the fill taking priority.
module brick_field_store
    import brick_field_pkg::*;
#(
    parameter int N      = 128,
    parameter int IW     = 7,
    parameter int HITS_W = 2
) (
    input  logic              clk,
    input  logic [IW-1:0]     rd_addr_i,
    output logic [HITS_W-1:0] rd_data_o,
    input  logic              fill_we_i,
    input  logic [IW-1:0]     fill_addr_i,
    input  logic [HITS_W-1:0] fill_data_i,
    input  logic              hit_we_i,
    input  logic [IW-1:0]     hit_addr_i,
    input  logic [HITS_W-1:0] hit_data_i
);

    logic [HITS_W-1:0] mem_q [N];
    logic              we;
    logic [IW-1:0]     wrAddr;
    logic [HITS_W-1:0] wrData;

    // Pick the single write for this clock; a running fill owns the port.
    always_comb begin
        we     = fill_we_i | hit_we_i;
        wrAddr = hit_addr_i;
        wrData = hit_data_i;
        if (fill_we_i) begin
            wrAddr = fill_addr_i;
            wrData = fill_data_i;
        end
    end

    // Contents are only meaningful after a fill, so the array has no reset.
    always_ff @(posedge clk) begin
        if (we) mem_q[wrAddr] <= wrData;
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/brick_field.sv
// Brick-wall controller: beam-driven scan of the brick grid, per-frame hit
// application, live brick counting and wall refill for each new level.
module brick_field
    import brick_field_pkg::*;
#(
    parameter int BRICKS_H = 16,
    parameter int BRICKS_V = 8,
    parameter int BW_LOG2  = 5,
    parameter int BH_LOG2  = 4,
    parameter int TOP_Y    = 128,
    parameter int LEFT_X   = 16,
    parameter int HITS_W   = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [9:0]                             hpos_i,
    input  logic [9:0]                             vpos_i,
    input  logic                                   vsync_i,
    input  logic                                   hit_i,
    input  logic                                   refill_i,
    input  logic [HITS_W-1:0]                      level_i,
    output logic                                   brick_present_o,
    output logic [HITS_W-1:0]                      brick_strength_o,
    output logic                                   brick_gfx_o,
    output logic                                   incscore_o,
    output logic [$clog2(BRICKS_H*BRICKS_V+1)-1:0] bricks_left_o,
    output logic                                   level_clear_o,
    output logic                                   busy_o
);

    localparam int N  = BRICKS_H * BRICKS_V;
    localparam int IW = idxWidth(N);
    localparam int CW = $clog2(N + 1);

    fill_state_t       state_q;
    logic [IW-1:0]     fillIdx_q;
    logic [HITS_W-1:0] fillVal_q;
    logic [CW-1:0]     bricksLeft_q;
    logic              incscore_q;
    logic [IW-1:0]     index_q;
    logic              idxValid_q;
    logic [IW-1:0]     presentIdx_q;
    logic              brick_present_q;
    logic [HITS_W-1:0] brick_strength_q;
    logic [N-1:0]      lock_q;
    logic [N-1:0]      lock_d;

    logic [9:0]        dy, dx, rowFull, colFull;
    logic              inArea, cellStart, hitOk, fwd;
    logic [IW-1:0]     cellIdx;
    logic [HITS_W-1:0] rdData, scanData, newStrength, refillVal;

    // Wall-relative beam offsets wrap as 10-bit unsigned, so positions left
    // of or above the wall land far outside the grid and fail the area test.
    assign dy        = vpos_i - 10'(TOP_Y);
    assign dx        = hpos_i - 10'(LEFT_X);
    assign rowFull   = dy >> BH_LOG2;
    assign colFull   = dx >> BW_LOG2;
    assign inArea    = (rowFull < 10'(BRICKS_V)) && (colFull < 10'(BRICKS_H));
    assign cellStart = (dx[BW_LOG2-1:0] == '0);
    assign cellIdx   = IW'(int'(rowFull) * BRICKS_H + int'(colFull));

    assign newStrength = brick_strength_q - HITS_W'(1);
    assign refillVal   = (level_i == '0) ? HITS_W'(1) : level_i;
    assign hitOk       = hit_i && brick_present_q && (state_q == IDLE)
                         && !lock_q[presentIdx_q] && !refill_i;
    // A hit written this clock to the cell being rescanned is forwarded so
    // the displayed strength never shows the pre-hit value for a clock.
    assign fwd         = hitOk && (presentIdx_q == index_q);
    assign scanData    = fwd ? newStrength : rdData;

    brick_field_store #(
        .N      (N),
        .IW     (IW),
        .HITS_W (HITS_W)
    ) u_store (
        .clk         (clk),
        .rd_addr_i   (index_q),
        .rd_data_o   (rdData),
        .fill_we_i   (state_q == FILL),
        .fill_addr_i (fillIdx_q),
        .fill_data_i (fillVal_q),
        .hit_we_i    (hitOk),
        .hit_addr_i  (presentIdx_q),
        .hit_data_i  (newStrength)
    );

    // Two-stage scan: latch the cell index at each cell start, then load that
    // cell's strength into the output registers on the following clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_q          <= '0;
            idxValid_q       <= 1'b0;
            presentIdx_q     <= '0;
            brick_present_q  <= 1'b0;
            brick_strength_q <= '0;
        end else begin
            if (inArea && cellStart) begin
                index_q    <= cellIdx;
                idxValid_q <= 1'b1;
            end else if (!inArea) begin
                idxValid_q <= 1'b0;
            end
            if (!inArea || (state_q == FILL) || !idxValid_q) begin
                brick_present_q  <= 1'b0;
                brick_strength_q <= '0;
            end else begin
                brick_present_q  <= (scanData != '0);
                brick_strength_q <= scanData;
                presentIdx_q     <= index_q;
            end
        end
    end

    // Per-brick hit lock: vsync releases every brick, a hit locks its brick.
    always_comb begin
        lock_d = vsync_i ? '0 : lock_q;
        if (hitOk) lock_d[presentIdx_q] = 1'b1;
    end

    // Lock register for the once-per-frame hit rule.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lock_q <= '0;
        else       lock_q <= lock_d;
    end

    // Level FSM with the fill walker, brick counter and score pulse; a
    // refill always restarts the walk and swallows any same-clock hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            fillIdx_q    <= '0;
            fillVal_q    <= HITS_W'(1);
            bricksLeft_q <= '0;
            incscore_q   <= 1'b0;
        end else begin
            incscore_q <= 1'b0;
            if (refill_i) begin
                fillVal_q <= refillVal;
                fillIdx_q <= '0;
                state_q   <= FILL;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (hitOk && (newStrength == '0)) begin
                            incscore_q <= 1'b1;
                            if (bricksLeft_q != '0) bricksLeft_q <= bricksLeft_q - CW'(1);
                        end
                    end
                    FILL: begin
                        if (fillIdx_q == IW'(N - 1)) begin
                            bricksLeft_q <= CW'(N);
                            state_q      <= IDLE;
                        end else begin
                            fillIdx_q <= fillIdx_q + IW'(1);
                        end
                    end
                    default: state_q <= FILL;
                endcase
            end
        end
    end

    assign brick_present_o  = brick_present_q;
    assign brick_strength_o = brick_strength_q;
    assign brick_gfx_o      = brick_present_q && (dy[BH_LOG2-1:0] != '0)
                              && (dx[BW_LOG2-1:0] != '1);
    assign incscore_o       = incscore_q;
    assign bricks_left_o    = bricksLeft_q;
    assign level_clear_o    = (bricksLeft_q == '0) && (state_q == IDLE);
    assign busy_o           = (state_q == FILL);

endmodule

// File: tb/tb_brick_field.sv
// Scoreboard bench for brick_field: stimulus queues expected values, a
// negedge monitor pops them and compares against the live DUT outputs.
module tb_brick_field;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hpos_i, vpos_i;
    logic       vsync_i, hit_i, refill_i;
    logic [1:0] level_i;
    logic       brick_present_o, brick_gfx_o, incscore_o, level_clear_o, busy_o;
    logic [1:0] brick_strength_o;
    logic [7:0] bricks_left_o;

    brick_field dut (
        .clk              (clk),
        .reset            (reset),
        .hpos_i           (hpos_i),
        .vpos_i           (vpos_i),
        .vsync_i          (vsync_i),
        .hit_i            (hit_i),
        .refill_i         (refill_i),
        .level_i          (level_i),
        .brick_present_o  (brick_present_o),
        .brick_strength_o (brick_strength_o),
        .brick_gfx_o      (brick_gfx_o),
        .incscore_o       (incscore_o),
        .bricks_left_o    (bricks_left_o),
        .level_clear_o    (level_clear_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    localparam int SEL_PRESENT = 0, SEL_STRENGTH = 1, SEL_GFX = 2, SEL_LEFT = 3;
    localparam int SEL_CLEAR = 4, SEL_BUSY = 5, SEL_INC = 6, SEL_BENCH = 7;

    typedef struct {
        string name;
        int    sel;
        int    expVal;
        int    actVal;
    } expect_t;

    expect_t sbQueue[$];
    expect_t e;
    int      vectors = 0;
    int      miscompares = 0;
    int      incCount = 0;
    int      act;

    function int sampleSel(input int sel, input int benchVal);
        case (sel)
            SEL_PRESENT:  return int'(brick_present_o);
            SEL_STRENGTH: return int'(brick_strength_o);
            SEL_GFX:      return int'(brick_gfx_o);
            SEL_LEFT:     return int'(bricks_left_o);
            SEL_CLEAR:    return int'(level_clear_o);
            SEL_BUSY:     return int'(busy_o);
            SEL_INC:      return incCount;
            default:      return benchVal;
        endcase
    endfunction

    // Monitor: count score pulses, then compare every pending expectation.
    always @(negedge clk) begin
        if (incscore_o === 1'b1) incCount++;
        while (sbQueue.size() > 0) begin
            e   = sbQueue.pop_front();
            act = sampleSel(e.sel, e.actVal);
            vectors++;
            if (act != e.expVal) begin
                miscompares++;
                $display("[TB] FAIL %s: got %0d, expected %0d", e.name, act, e.expVal);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int sel, input int expVal,
                               input int actVal = 0);
        expect_t x;
        x.name   = name;
        x.sel    = sel;
        x.expVal = expVal;
        x.actVal = actVal;
        sbQueue.push_back(x);
    endtask

    task automatic applyStimulus(input int h, input int v, input logic hitV,
                                 input logic refV, input logic vs);
        hpos_i   = 10'(h);
        vpos_i   = 10'(v);
        hit_i    = hitV;
        refill_i = refV;
        vsync_i  = vs;
        tick();
    endtask

    // Beam to cell start, one clock in, then park two pixels into the cell.
    task automatic viewCell(input int r, input int c);
        applyStimulus(16 + 32 * c, 129 + 16 * r, 1'b0, 1'b0, 1'b0);
        applyStimulus(17 + 32 * c, 129 + 16 * r, 1'b0, 1'b0, 1'b0);
        hpos_i = 10'(18 + 32 * c);
    endtask

    task automatic hitCell(input int r, input int c);
        viewCell(r, c);
        hit_i = 1'b1;
        tick();
        hit_i = 1'b0;
    endtask

    task automatic vsyncPulse();
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b1);
        vsync_i = 1'b0;
    endtask

    task automatic refillPulse(input logic [1:0] lvl);
        level_i = lvl;
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b0);
        refill_i = 1'b0;
    endtask

    task automatic waitFill(input string name);
        int cnt = 0;
        while (busy_o && cnt < 400) begin
            tick();
            cnt++;
        end
        checkOutput(name, SEL_BENCH, 128, cnt);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1;
        hpos_i = '0; vpos_i = '0; vsync_i = 1'b0; hit_i = 1'b0;
        refill_i = 1'b0; level_i = 2'd0;
        tick(); tick();
        checkOutput("rst_present", SEL_PRESENT, 0);
        checkOutput("rst_strength", SEL_STRENGTH, 0);
        checkOutput("rst_left", SEL_LEFT, 0);
        checkOutput("rst_clear", SEL_CLEAR, 0);
        checkOutput("rst_inc", SEL_INC, 0);
        checkOutput("rst_busy", SEL_BUSY, 1);
        drain();
        tick();
        reset = 1'b0;
        waitFill("init_fill_len");
        checkOutput("init_left", SEL_LEFT, 128);
        checkOutput("init_clear", SEL_CLEAR, 0);
        checkOutput("init_busy", SEL_BUSY, 0);
        drain();
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL direct_init_busy: got %0b, expected 0", busy_o);
        end
        vectors++;
        if (bricks_left_o !== 8'd128) begin
            miscompares++;
            $display("[TB] FAIL direct_init_left: got %0d, expected 128", bricks_left_o);
        end

        // Every cell holds strength 1 after the power-on fill.
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 16; c++) begin
                viewCell(r, c);
                checkOutput($sformatf("init_str_r%0dc%0d", r, c), SEL_STRENGTH, 1);
                drain();
            end
        end

        // Cell (0,0) timing and mortar lines.
        applyStimulus(16, 128, 1'b0, 1'b0, 1'b0);
        applyStimulus(17, 128, 1'b0, 1'b0, 1'b0);
        hpos_i = 10'd18;
        checkOutput("c00_present", SEL_PRESENT, 1);
        checkOutput("c00_strength", SEL_STRENGTH, 1);
        checkOutput("c00_gfx_topline", SEL_GFX, 0);
        drain();
        vpos_i = 10'd129;
        checkOutput("c00_gfx_body", SEL_GFX, 1);
        drain();
        hpos_i = 10'd47;
        checkOutput("c00_present_lastcol", SEL_PRESENT, 1);
        checkOutput("c00_gfx_lastcol", SEL_GFX, 0);
        drain();
        hpos_i = 10'd46;
        checkOutput("c00_gfx_col30", SEL_GFX, 1);
        drain();
        applyStimulus(15, 129, 1'b0, 1'b0, 1'b0);
        checkOutput("outside_present", SEL_PRESENT, 0);
        checkOutput("outside_strength", SEL_STRENGTH, 0);
        drain();

        // Level 3, one hit per frame on cell (2,5).
        refillPulse(2'd3);
        checkOutput("l3_busy", SEL_BUSY, 1);
        waitFill("l3_fill_len");
        viewCell(2, 5);
        checkOutput("l3_strength", SEL_STRENGTH, 3);
        drain();
        for (int f = 1; f <= 3; f++) begin
            vsyncPulse();
            hitCell(2, 5);
            checkOutput($sformatf("frame%0d_strength", f), SEL_STRENGTH, 3 - f);
            checkOutput($sformatf("frame%0d_present", f), SEL_PRESENT, (f < 3) ? 1 : 0);
            checkOutput($sformatf("frame%0d_inc", f), SEL_INC, (f == 3) ? 1 : 0);
            checkOutput($sformatf("frame%0d_left", f), SEL_LEFT, (f == 3) ? 127 : 128);
            drain();
        end
        tick();
        checkOutput("inc_single_pulse", SEL_INC, 1);
        drain();

        // Hit held across many clocks in one frame: exactly one decrement.
        vsyncPulse();
        viewCell(3, 3);
        hit_i = 1'b1;
        repeat (32) tick();
        hit_i = 1'b0;
        checkOutput("hold_strength", SEL_STRENGTH, 2);
        checkOutput("hold_inc", SEL_INC, 1);
        checkOutput("hold_left", SEL_LEFT, 127);
        drain();

        // Level 1, destroy the whole wall.
        refillPulse(2'd1);
        waitFill("l1_fill_len");
        checkOutput("l1_left", SEL_LEFT, 128);
        drain();
        vsyncPulse();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
                hitCell(r, c);
        tick();
        checkOutput("cleared_left", SEL_LEFT, 0);
        checkOutput("cleared_flag", SEL_CLEAR, 1);
        checkOutput("cleared_inc", SEL_INC, 129);
        drain();
        vectors++;
        if (level_clear_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL direct_cleared_flag: got %0b, expected 1", level_clear_o);
        end

        // Refill with level 0 behaves as level 1.
        refillPulse(2'd0);
        checkOutput("l0_clear_drop", SEL_CLEAR, 0);
        checkOutput("l0_busy", SEL_BUSY, 1);
        waitFill("l0_fill_len");
        checkOutput("l0_left", SEL_LEFT, 128);
        drain();
        viewCell(4, 9);
        checkOutput("l0_strength", SEL_STRENGTH, 1);
        drain();

        // Refill coincident with a qualifying hit: the hit is dropped.
        vsyncPulse();
        viewCell(1, 1);
        level_i  = 2'd1;
        hit_i    = 1'b1;
        refill_i = 1'b1;
        tick();
        hit_i    = 1'b0;
        refill_i = 1'b0;
        checkOutput("coinc_inc", SEL_INC, 129);
        checkOutput("coinc_left", SEL_LEFT, 128);
        checkOutput("coinc_busy", SEL_BUSY, 1);
        drain();
        waitFill("coinc_fill_len");
        drain();

        // Refill at fill index 60 restarts the full walk with the new level.
        refillPulse(2'd3);
        repeat (60) tick();
        refillPulse(2'd2);
        waitFill("restart_fill_len");
        drain();
        viewCell(0, 0);
        checkOutput("restart_str_first", SEL_STRENGTH, 2);
        drain();
        viewCell(1, 14);
        checkOutput("restart_str_idx30", SEL_STRENGTH, 2);
        drain();
        viewCell(7, 15);
        checkOutput("restart_str_last", SEL_STRENGTH, 2);
        drain();

        drain();
        while (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: got unchecked, expected checked", e.name);
        end
        if (vectors < 12) begin
            miscompares++;
            $display("[TB] FAIL vector_count: got %0d, expected at least 12", vectors);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
